led_strip_driver: RTL

- Serial WS2812-class strand driver on the clk_led domain, directly downstream of the LED color buffer.
- Walks LED addresses 0..NUM_LEDS-1. For each address it holds the address, waits for the buffer's color_valid, then latches the 24-bit colour.
- Shifts the colour out on a single-wire NRZ line: GRB order, MSB first.
- Each frame ends with a latch/reset low period. Frames repeat while enable is high.

---
 rtl/led_strip_driver.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/led_strip_driver.sv
// led_strip_driver
//   Single-wire NRZ driver for a WS2812-class LED strand. Walks LED addresses
//   0..NUM_LEDS-1, fetches a 24-bit colour per LED from the colour buffer,
//   shifts it out GRB / MSB first, and closes each frame with a low latch
//   period. Frames repeat while enable is high.
//
// Ports
//   clk_led                   LED clock
//   rst                       asynchronous, active-high reset
//   enable                    run frames continuously while high
//   next_led_request_address  address presented to the colour buffer
//   green_in/red_in/blue_in   colour from the buffer for that address
//   color_valid               buffer data stable for the current address
//   strand_out                registered serial data line
//   busy                      high whenever the driver is not idle
//   frame_done                one-cycle pulse after each latch period
//   fetch_timeout_err         sticky flag, set on any fetch timeout
module led_strip_driver #(
  parameter int unsigned NUM_LEDS          = 50,
  parameter int unsigned LED_ADDRESS_WIDTH = 10,
  parameter int unsigned T0H_CYCLES        = 40,
  parameter int unsigned T0L_CYCLES        = 85,
  parameter int unsigned T1H_CYCLES        = 80,
  parameter int unsigned T1L_CYCLES        = 45,
  parameter int unsigned RESET_CYCLES      = 5000,
  parameter int unsigned FETCH_MIN_CYCLES  = 2,
  parameter int unsigned FETCH_TIMEOUT     = 64
) (
  input  logic                         clk_led,
  input  logic                         rst,
  input  logic                         enable,
  output logic [LED_ADDRESS_WIDTH-1:0] next_led_request_address,
  input  logic [7:0]                   green_in,
  input  logic [7:0]                   red_in,
  input  logic [7:0]                   blue_in,
  input  logic                         color_valid,
  output logic                         strand_out,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         fetch_timeout_err
);

  localparam int unsigned MAX_H   = (T0H_CYCLES > T1H_CYCLES) ? T0H_CYCLES : T1H_CYCLES;
  localparam int unsigned MAX_L   = (T0L_CYCLES > T1L_CYCLES) ? T0L_CYCLES : T1L_CYCLES;
  localparam int unsigned MAX_HL  = (MAX_H > MAX_L) ? MAX_H : MAX_L;
  localparam int unsigned MAX_T   = (MAX_HL > RESET_CYCLES) ? MAX_HL : RESET_CYCLES;
  localparam int unsigned TIMER_W = $clog2(MAX_T + 1);
  localparam int unsigned FETCH_W = $clog2(FETCH_TIMEOUT + 1);
  localparam int unsigned IDX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [TIMER_W-1:0] T0H_LAST   = TIMER_W'(T0H_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T0L_LAST   = TIMER_W'(T0L_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T1H_LAST   = TIMER_W'(T1H_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T1L_LAST   = TIMER_W'(T1L_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RESET_LAST = TIMER_W'(RESET_CYCLES - 1);
  localparam logic [FETCH_W-1:0] FETCH_MIN  = FETCH_W'(FETCH_MIN_CYCLES);
  localparam logic [FETCH_W-1:0] FETCH_LAST = FETCH_W'(FETCH_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND_HIGH,
    SEND_LOW,
    LATCH
  } state_t;

  state_t               state, state_next;
  logic [IDX_W-1:0]     led_idx, led_idx_next;
  logic [FETCH_W-1:0]   fetch_cnt, fetch_cnt_next;
  logic [4:0]           bit_cnt, bit_cnt_next;
  logic [23:0]          shift_reg, shift_next;
  logic [TIMER_W-1:0]   timer, timer_next;
  logic                 err_next;
  logic                 frame_done_next;
  logic [TIMER_W-1:0]   high_last;
  logic [TIMER_W-1:0]   low_last;

  // The bit being sent is always shift_reg[23]; it only shifts when leaving SEND_LOW.
  assign high_last = shift_reg[23] ? T1H_LAST : T0H_LAST;
  assign low_last  = shift_reg[23] ? T1L_LAST : T0L_LAST;

  assign busy                     = (state != IDLE);
  assign next_led_request_address = LED_ADDRESS_WIDTH'(led_idx);

  always_comb begin
    state_next      = state;
    led_idx_next    = led_idx;
    fetch_cnt_next  = fetch_cnt;
    bit_cnt_next    = bit_cnt;
    shift_next      = shift_reg;
    timer_next      = timer;
    err_next        = fetch_timeout_err;
    frame_done_next = 1'b0;
    case (state)
      IDLE: begin
        led_idx_next = '0;
        if (enable) begin
          fetch_cnt_next = '0;
          state_next     = FETCH;
        end
      end
      FETCH: begin
        if (fetch_cnt != '1) fetch_cnt_next = fetch_cnt + FETCH_W'(1);
        // Accept wins over timeout when both land on the same cycle.
        if (color_valid && (fetch_cnt >= FETCH_MIN)) begin
          shift_next   = {green_in, red_in, blue_in};
          bit_cnt_next = 5'd23;
          timer_next   = '0;
          state_next   = SEND_HIGH;
        end else if (fetch_cnt >= FETCH_LAST) begin
          shift_next   = '0;
          err_next     = 1'b1;
          bit_cnt_next = 5'd23;
          timer_next   = '0;
          state_next   = SEND_HIGH;
        end
      end
      SEND_HIGH: begin
        if (timer >= high_last) begin
          timer_next = '0;
          state_next = SEND_LOW;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
      SEND_LOW: begin
        if (timer >= low_last) begin
          timer_next = '0;
          if (bit_cnt != 5'd0) begin
            shift_next   = {shift_reg[22:0], 1'b0};
            bit_cnt_next = bit_cnt - 5'd1;
            state_next   = SEND_HIGH;
          end else if (led_idx < LAST_IDX) begin
            led_idx_next   = led_idx + IDX_W'(1);
            fetch_cnt_next = '0;
            state_next     = FETCH;
          end else begin
            state_next = LATCH;
          end
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
      LATCH: begin
        if (timer >= RESET_LAST) begin
          timer_next      = '0;
          led_idx_next    = '0;
          fetch_cnt_next  = '0;
          frame_done_next = 1'b1;
          state_next      = enable ? FETCH : IDLE;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_led or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      led_idx           <= '0;
      fetch_cnt         <= '0;
      bit_cnt           <= '0;
      shift_reg         <= '0;
      timer             <= '0;
      strand_out        <= 1'b0;
      frame_done        <= 1'b0;
      fetch_timeout_err <= 1'b0;
    end else begin
      state             <= state_next;
      led_idx           <= led_idx_next;
      fetch_cnt         <= fetch_cnt_next;
      bit_cnt           <= bit_cnt_next;
      shift_reg         <= shift_next;
      timer             <= timer_next;
      // Registered line is high exactly while the FSM sits in SEND_HIGH.
      strand_out        <= (state_next == SEND_HIGH);
      frame_done        <= frame_done_next;
      fetch_timeout_err <= err_next;
    end
  end

endmodule
